// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - load/store port between the MIPS datapath and the data memory responder
interface dmem_responder_if;
    logic        memread;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        fault;

    modport master (
        output memread, memwrite, addr, wdata,
        input  rdata, stall, done, fault
    );

    modport slave (
        input  memread, memwrite, addr, wdata,
        output rdata, stall, done, fault
    );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-stated data memory with stall, done pulse and sticky fault flag
module dmem_responder #(
    parameter int DEPTH = 64,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    dmem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic [31:0] addr_q, wdata_q;
    logic        wr_q;
    logic        req, latch, commit;
    logic [31:0] acc_addr, acc_wdata;
    logic        acc_wr;
    logic        bad;
    logic [AW-1:0] idx;
    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;
    logic        fault_q;

    assign req = bus.memread | bus.memwrite;

    // In IDLE the access is described by the live inputs so a WAIT=0 access
    // can commit on the same edge that accepts it; afterwards the latched copy is used.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        latch     = 1'b0;
        commit    = 1'b0;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_wr    = wr_q;
        case (state)
            IDLE: begin
                acc_addr  = bus.addr;
                acc_wdata = bus.wdata;
                acc_wr    = bus.memwrite;
                if (req) begin
                    latch = 1'b1;
                    if (WAIT == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = 4'(WAIT - 1);
                    end
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Out-of-range is any set bit above the word index, so nothing aliases.
    assign bad = (|acc_addr[1:0]) | (|acc_addr[31:AW+2]);
    assign idx = acc_addr[AW+1:2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wr_q    <= 1'b0;
            rdata_q <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            if (latch) begin
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
                wr_q    <= bus.memwrite;
            end
            if (commit && !acc_wr) begin
                rdata_q <= bad ? 32'd0 : mem[idx];
            end
            if (commit && bad) begin
                fault_q <= 1'b1;
            end
        end
    end

    // RAM content survives reset; a reset edge still blocks a pending store.
    always_ff @(posedge clk) begin
        if (!reset && commit && acc_wr && !bad) begin
            mem[idx] <= acc_wdata;
        end
    end

    assign bus.stall = !reset && ((state == IDLE && req) || state == BUSY);
    assign bus.done  = (state == RESP);
    assign bus.rdata = rdata_q;
    assign bus.fault = fault_q;
endmodule
